axi_lite_arbiter: RTL and testbench

- Two-requester master-side controller that shares a single AXI-lite slave (address/data channels, no write-response channel) between two local requesters.
- Each requester issues single-beat read or write commands over a simple req/done interface.
- The block does round-robin arbitration, runs one AXI-lite transaction at a time, and returns read data.
- A per-transaction watchdog ends any transaction that stalls and flags it with an error.
- Sits between the two clients and the slave's channel signals.

---
 rtl/axi_lite_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_arbiter.sv
// Round-robin master-side controller sharing one AXI-lite slave (no write response
// channel) between two single-beat requesters, with a per-transaction watchdog abort.
module axi_lite_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              done0,
   output logic              done1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] write_addr,
   output logic              write_addr_valid,
   input  logic              write_addr_ready,
   output logic [DATA_W-1:0] write_data,
   output logic              write_data_valid,
   input  logic              write_data_ready,
   output logic [ADDR_W-1:0] read_addr,
   output logic              read_addr_valid,
   input  logic              read_addr_ready,
   input  logic [DATA_W-1:0] read_data,
   input  logic              read_data_valid,
   output logic              read_data_ready
);

   typedef enum logic [2:0] {IDLE, WR, RD_A, RD_D, DONE} state_t;

   localparam int               CNT_W    = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t            state, state_nxt;
   logic              grant, last_grant, after_done, abort;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [CNT_W-1:0]  wd_cnt;
   logic              wa_valid, wd_valid, ra_valid, rd_ready;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;

   logic req_eff0, req_eff1, win, timeout, wa_left, wd_left;
   logic wa_nxt, wd_nxt, ra_nxt, rd_nxt, abort_nxt, load, capture;

   // The requester just served may still hold req in the IDLE cycle after DONE.
   assign req_eff0 = req0 && !(after_done && !last_grant);
   assign req_eff1 = req1 && !(after_done && last_grant);
   assign win      = (req_eff0 && req_eff1) ? !last_grant : req_eff1;
   assign timeout  = (wd_cnt >= CNT_LAST);
   assign wa_left  = wa_valid && !write_addr_ready;
   assign wd_left  = wd_valid && !write_data_ready;

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_nxt = state;
      wa_nxt    = wa_valid;
      wd_nxt    = wd_valid;
      ra_nxt    = ra_valid;
      rd_nxt    = rd_ready;
      abort_nxt = abort;
      load      = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (req_eff0 || req_eff1) begin
               load      = 1'b1;
               abort_nxt = 1'b0;
               if (win ? we1 : we0) begin
                  state_nxt = WR;
                  wa_nxt    = 1'b1;
                  wd_nxt    = 1'b1;
               end else begin
                  state_nxt = RD_A;
                  ra_nxt    = 1'b1;
               end
            end
         end
         WR: begin
            wa_nxt = wa_left;
            wd_nxt = wd_left;
            if (!wa_left && !wd_left) begin
               state_nxt = DONE;
            end else if (timeout) begin
               wa_nxt    = 1'b0;
               wd_nxt    = 1'b0;
               abort_nxt = 1'b1;
               state_nxt = DONE;
            end
         end
         RD_A: begin
            if (read_addr_ready) begin
               ra_nxt    = 1'b0;
               rd_nxt    = 1'b1;
               state_nxt = RD_D;
            end else if (timeout) begin
               ra_nxt    = 1'b0;
               abort_nxt = 1'b1;
               state_nxt = DONE;
            end
         end
         RD_D: begin
            if (read_data_valid) begin
               rd_nxt    = 1'b0;
               capture   = 1'b1;
               state_nxt = DONE;
            end else if (timeout) begin
               rd_nxt    = 1'b0;
               abort_nxt = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         grant      <= 1'b0;
         last_grant <= 1'b1;
         after_done <= 1'b0;
         abort      <= 1'b0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
         wd_cnt     <= '0;
         wa_valid   <= 1'b0;
         wd_valid   <= 1'b0;
         ra_valid   <= 1'b0;
         rd_ready   <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         wa_valid   <= wa_nxt;
         wd_valid   <= wd_nxt;
         ra_valid   <= ra_nxt;
         rd_ready   <= rd_nxt;
         abort      <= abort_nxt;
         after_done <= (state == DONE);
         if (state == DONE) last_grant <= grant;
         if (load) begin
            grant     <= win;
            cmd_addr  <= win ? addr1 : addr0;
            cmd_wdata <= win ? wdata1 : wdata0;
            wd_cnt    <= '0;
         end else if (state == WR || state == RD_A || state == RD_D) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
         end
         if (capture && grant)  rdata1_q <= read_data;
         if (capture && !grant) rdata0_q <= read_data;
      end
   end

   assign write_addr       = cmd_addr;
   assign write_data       = cmd_wdata;
   assign read_addr        = cmd_addr;
   assign write_addr_valid = wa_valid;
   assign write_data_valid = wd_valid;
   assign read_addr_valid  = ra_valid;
   assign read_data_ready  = rd_ready;
   assign done0            = (state == DONE) && !grant;
   assign done1            = (state == DONE) && grant;
   assign err0             = done0 && abort;
   assign err1             = done1 && abort;
   assign rdata0           = rdata0_q;
   assign rdata1           = rdata1_q;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Self-checking bench for axi_lite_arbiter: a table of single transactions against a
// latency-configurable slave, plus arbitration and mid-transaction reset sequences.
module tb_axi_lite_arbiter;
   localparam int          ADDR_W      = 32;
   localparam int          DATA_W      = 32;
   localparam int          TIMEOUT_CYC = 8;
   localparam int unsigned NEVER       = 1000;
   localparam logic [31:0] SALT        = 32'hA5A5_0000;

   logic              clk, rstn;
   logic              req0, req1, we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              done0, done1, err0, err1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic [ADDR_W-1:0] write_addr, read_addr;
   logic [DATA_W-1:0] write_data, read_data;
   logic              write_addr_valid, write_addr_ready, write_data_valid, write_data_ready;
   logic              read_addr_valid, read_addr_ready, read_data_valid, read_data_ready;

   axi_lite_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk(clk), .rstn(rstn),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .done0(done0), .done1(done1), .err0(err0), .err1(err1),
      .rdata0(rdata0), .rdata1(rdata1),
      .write_addr(write_addr), .write_addr_valid(write_addr_valid), .write_addr_ready(write_addr_ready),
      .write_data(write_data), .write_data_valid(write_data_valid), .write_data_ready(write_data_ready),
      .read_addr(read_addr), .read_addr_valid(read_addr_valid), .read_addr_ready(read_addr_ready),
      .read_data(read_data), .read_data_valid(read_data_valid), .read_data_ready(read_data_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] rdata_exp [2];

   typedef struct {
      int unsigned who;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      int unsigned aw_lat;
      int unsigned w_lat;
      int unsigned ar_lat;
      int unsigned r_lat;
      bit          exp_err;
   } txn_t;

   txn_t tbl [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic txn_t mk(input int unsigned who, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rd,
                               input int unsigned aw_lat, input int unsigned w_lat,
                               input int unsigned ar_lat, input int unsigned r_lat,
                               input bit exp_err);
      txn_t t;
      t.who = who; t.we = we; t.addr = addr; t.wdata = wdata; t.rd = rd;
      t.aw_lat = aw_lat; t.w_lat = w_lat; t.ar_lat = ar_lat; t.r_lat = r_lat;
      t.exp_err = exp_err;
      return t;
   endfunction

   task automatic set_req(input int unsigned who, input logic r, input txn_t t);
      if (who == 0) begin
         req0 = r; we0 = t.we; addr0 = t.addr; wdata0 = t.wdata;
      end else begin
         req1 = r; we1 = t.we; addr1 = t.addr; wdata1 = t.wdata;
      end
   endtask

   task automatic slave_idle();
      write_addr_ready = 1'b0; write_data_ready = 1'b0;
      read_addr_ready  = 1'b0; read_data_valid  = 1'b0; read_data = '0;
   endtask

   task automatic run_txn(input txn_t t, input string tag);
      int unsigned aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0;
      int          aw_hs = 0, w_hs = 0, ar_hs = 0;
      int          cyc = 0, first_v = -1, done_cyc = 0;
      logic [31:0] aw_a = '0, w_d = '0, ar_a = '0, rd_seen = '0;
      bit          done_seen = 0, wrong_ch = 0, other_done = 0, w_first = 0, err_seen = 0;
      bit          post = 0;
      bit          exp_aw, exp_w, exp_ar;
      exp_aw = t.we && (t.aw_lat < NEVER);
      exp_w  = t.we && (t.w_lat < NEVER);
      exp_ar = !t.we && (t.ar_lat < NEVER);
      @(negedge clk);
      set_req(t.who, 1'b1, t);
      while (!done_seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (first_v < 0 && (write_addr_valid || write_data_valid || read_addr_valid)) first_v = cyc;
         if (t.we ? (read_addr_valid || read_data_ready) : (write_addr_valid || write_data_valid))
            wrong_ch = 1;
         if (write_addr_valid && !write_data_valid) w_first = 1;
         if (t.who == 0 ? done1 : done0) other_done = 1;
         if (t.who == 0 ? done0 : done1) begin
            done_seen = 1;
            done_cyc  = cyc;
            err_seen  = (t.who == 0) ? err0 : err1;
            rd_seen   = (t.who == 0) ? rdata0 : rdata1;
         end
         write_addr_ready = write_addr_valid && (aw_wait >= t.aw_lat);
         write_data_ready = write_data_valid && (w_wait >= t.w_lat);
         read_addr_ready  = read_addr_valid && (ar_wait >= t.ar_lat);
         read_data        = t.rd;
         read_data_valid  = read_data_ready && (r_wait >= t.r_lat);
         if (write_addr_valid) aw_wait++;
         if (write_data_valid) w_wait++;
         if (read_addr_valid)  ar_wait++;
         if (read_data_ready)  r_wait++;
         if (write_addr_valid && write_addr_ready) begin aw_hs++; aw_a = write_addr; end
         if (write_data_valid && write_data_ready) begin w_hs++;  w_d  = write_data; end
         if (read_addr_valid && read_addr_ready)   begin ar_hs++; ar_a = read_addr;  end
      end
      slave_idle();
      // Hold req through the IDLE after DONE, then drop it; nothing may restart.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done0 || done1 || write_addr_valid || write_data_valid || read_addr_valid || read_data_ready)
            post = 1;
         if (i == 1) set_req(t.who, 1'b0, t);
      end
      if (!t.we && !t.exp_err) rdata_exp[t.who] = t.rd;
      check({tag, " done pulse"}, done_seen, 1);
      check({tag, " err"}, err_seen, t.exp_err);
      check({tag, " rdata at done"}, rd_seen, rdata_exp[t.who]);
      check({tag, " other done"}, other_done, 0);
      check({tag, " wrong channel"}, wrong_ch, 0);
      check({tag, " aw handshakes"}, aw_hs, exp_aw);
      check({tag, " w handshakes"}, w_hs, exp_w);
      check({tag, " ar handshakes"}, ar_hs, exp_ar);
      check({tag, " quiet after done"}, post, 0);
      if (exp_aw) check({tag, " write_addr"}, aw_a, t.addr);
      if (exp_w)  check({tag, " write_data"}, w_d, t.wdata);
      if (exp_ar) check({tag, " read_addr"}, ar_a, t.addr);
      if (t.we)   check({tag, " wdata valid dropped first"}, w_first, t.w_lat < t.aw_lat);
      if (t.exp_err) check({tag, " abort latency ok"}, (done_cyc - first_v) <= TIMEOUT_CYC, 1);
   endtask

   task automatic arb_run();
      logic [31:0] q0 [$];
      logic [31:0] q1 [$];
      logic [31:0] ar_log [$];
      int          who_log [$];
      int          hold0 = 0, hold1 = 0, cyc = 0;
      logic [31:0] last_ar = '0;
      bit          wr_seen = 0;
      logic [31:0] exp_ar [4];
      int          exp_who [4];
      q0 = '{32'h4, 32'hC};
      q1 = '{32'h8, 32'h18};
      exp_ar  = '{32'h4, 32'h8, 32'hC, 32'h18};
      exp_who = '{0, 1, 0, 1};
      @(negedge clk);
      we0 = 1'b0; we1 = 1'b0;
      req0 = 1'b1; addr0 = q0[0];
      req1 = 1'b1; addr1 = q1[0];
      while (who_log.size() < 4 && cyc < 80) begin
         @(negedge clk);
         cyc++;
         if (write_addr_valid || write_data_valid) wr_seen = 1;
         if (done0 && q0.size() > 0) begin
            who_log.push_back(0);
            check("arb rdata0", rdata0, q0[0] ^ SALT);
            void'(q0.pop_front());
            hold0 = 2;
         end
         if (done1 && q1.size() > 0) begin
            who_log.push_back(1);
            check("arb rdata1", rdata1, q1[0] ^ SALT);
            void'(q1.pop_front());
            hold1 = 2;
         end
         if (hold0 > 0) hold0--;
         else if (q0.size() > 0) begin req0 = 1'b1; addr0 = q0[0]; end
         else req0 = 1'b0;
         if (hold1 > 0) hold1--;
         else if (q1.size() > 0) begin req1 = 1'b1; addr1 = q1[0]; end
         else req1 = 1'b0;
         read_addr_ready = read_addr_valid;
         if (read_addr_valid) begin ar_log.push_back(read_addr); last_ar = read_addr; end
         read_data       = last_ar ^ SALT;
         read_data_valid = read_data_ready;
      end
      req0 = 1'b0; req1 = 1'b0;
      slave_idle();
      check("arb done count", who_log.size(), 4);
      check("arb no write valid", wr_seen, 0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("arb grant %0d", i), (i < who_log.size()) ? who_log[i] : -1, exp_who[i]);
         check($sformatf("arb read_addr %0d", i), (i < ar_log.size()) ? ar_log[i] : 32'hFFFF_FFFF, exp_ar[i]);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global timeout reached");
      $fatal(1, "bench did not finish");
   end

   initial begin
      bit rst_done;
      int wait_cyc;
      rstn = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      slave_idle();
      rdata_exp[0] = '0; rdata_exp[1] = '0;

      tbl[0] = mk(0, 1, 32'h10, 32'hDEAD_BEEF, 32'h0,          1,     1,     0, 0,     0);
      tbl[1] = mk(1, 0, 32'h10, 32'h0,         32'hDEAD_BEEF,  0,     0,     0, 0,     0);
      tbl[2] = mk(0, 1, 32'h20, 32'h1234_5678, 32'h0,          4,     1,     0, 0,     0);
      tbl[3] = mk(1, 0, 32'h30, 32'h0,         32'h1111_2222,  0,     0,     1, NEVER, 1);
      tbl[4] = mk(1, 0, 32'h34, 32'h0,         32'hCAFE_F00D,  0,     0,     0, 2,     0);
      tbl[5] = mk(0, 1, 32'h40, 32'h7777_8888, 32'h0,          NEVER, 0,     0, 0,     1);
      tbl[6] = mk(0, 0, 32'h44, 32'h0,         32'h0BAD_BEEF,  0,     0,     2, 1,     0);
      tbl[7] = mk(1, 1, 32'h48, 32'h0102_0304, 32'h0,          0,     0,     0, 0,     0);

      #12;
      check("reset valids", {write_addr_valid, write_data_valid, read_addr_valid, read_data_ready}, 0);
      check("reset done/err", {done0, done1, err0, err1}, 0);
      check("reset rdata", {rdata0, rdata1}, 0);
      check("reset addr/data", {write_addr, write_data}, 0);
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("txn%0d", i));

      // Both requesters asserted straight out of reset.
      @(negedge clk);
      rstn = 1'b0;
      rdata_exp[0] = '0; rdata_exp[1] = '0;
      @(negedge clk);
      rstn = 1'b1;
      arb_run();

      // Reset while a write is stuck in WR.
      repeat (2) @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h50; wdata0 = 32'h5555_AAAA;
      wait_cyc = 0;
      while (!write_addr_valid && wait_cyc < 10) begin @(negedge clk); wait_cyc++; end
      check("rst-mid write_addr_valid reached", write_addr_valid, 1);
      #2 rstn = 1'b0;
      #1;
      check("rst-mid valids async low", {write_addr_valid, write_data_valid, read_addr_valid, read_data_ready}, 0);
      rdata_exp[0] = '0; rdata_exp[1] = '0;
      rst_done = 0;
      @(negedge clk);
      if (done0 || done1) rst_done = 1;
      req0 = 1'b0;
      rstn = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (done0 || done1 || write_addr_valid) rst_done = 1;
      end
      check("rst-mid no done", rst_done, 0);
      check("rst-mid rdata cleared", {rdata0, rdata1}, 0);
      run_txn(mk(0, 1, 32'h60, 32'h0F0F_0F0F, 32'h0, 0, 2, 0, 0, 0), "post-reset write");
      run_txn(mk(0, 0, 32'h64, 32'h0, 32'h4242_4242, 0, 0, 0, 0, 0), "post-reset read");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
